// File: rtl/sram_ahb_burst_master.sv
// rtl/sram_ahb_burst_master.sv - AHB-Lite incrementing burst master for SRAM read/write commands
module sram_ahb_burst_master #(
  parameter int BOUNDARY = 1024
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] wd_data,
  output logic        wd_pop,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUS,
    S_TAIL,
    S_ERR,
    S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  len_q;
  logic [4:0]  issued;
  logic [4:0]  completed;

  logic [31:0] boundary_off;
  logic [32:0] burst_span;
  logic        cmd_illegal;
  logic [2:0]  burst_code;
  logic        resp_ok;
  logic        addr_accept;
  logic        data_done;

  // Bus width is fixed at one 32-bit word per beat
  assign hsize = 3'b010;

  // RETRY and SPLIT are folded into the error path along with ERROR
  assign resp_ok = (hresp == RESP_OKAY);

  // The current address phase is taken by the slave on any OKAY cycle with hready high
  assign addr_accept = (state == S_BUS) && hready && resp_ok;

  // A data phase is in flight whenever more addresses were accepted than data beats finished
  assign data_done = ((state == S_BUS) || (state == S_TAIL)) && hready && resp_ok &&
                     (issued != completed);

  // Show-ahead source is consumed exactly when a write address phase is accepted
  assign wd_pop = addr_accept && hwrite;

  // Command legality: word alignment, 1..16 beats, and no crossing of a BOUNDARY-aligned window
  always_comb begin
    boundary_off = cmd_addr % 32'(BOUNDARY);
    burst_span   = {1'b0, boundary_off} + {26'd0, cmd_len, 2'b00};
    cmd_illegal  = (cmd_addr[1:0] != 2'b00) || (cmd_len == 5'd0) || (cmd_len > 5'd16) ||
                   (burst_span > 33'(BOUNDARY));
  end

  // Fixed-length burst codes where the length matches, undefined-length INCR otherwise
  always_comb begin
    case (cmd_len)
      5'd1:    burst_code = 3'b000;
      5'd4:    burst_code = 3'b011;
      5'd8:    burst_code = 3'b101;
      5'd16:   burst_code = 3'b111;
      default: burst_code = 3'b001;
    endcase
  end

  // Command sequencing, address/data phase tracking and all registered outputs
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= S_IDLE;
      len_q     <= 5'd0;
      issued    <= 5'd0;
      completed <= 5'd0;
      cmd_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      htrans    <= TRANS_IDLE;
      haddr     <= 32'd0;
      hwrite    <= 1'b0;
      hburst    <= 3'b000;
      hwdata    <= 32'd0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;

      if (data_done) begin
        completed <= completed + 5'd1;
        if (!hwrite) begin
          rd_valid <= 1'b1;
          rd_data  <= hrdata;
        end
      end

      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            issued    <= 5'd0;
            completed <= 5'd0;
            if (cmd_illegal) begin
              // Rejected commands never touch the bus
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= S_BUS;
              htrans <= TRANS_NONSEQ;
              haddr  <= cmd_addr;
              hwrite <= cmd_write;
              hburst <= burst_code;
            end
          end
        end

        S_BUS: begin
          if (!resp_ok) begin
            // Abandon the remaining beats; the pending address is withdrawn
            htrans <= TRANS_IDLE;
            if (hready) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (hready) begin
            issued <= issued + 5'd1;
            if (hwrite) begin
              hwdata <= wd_data;
            end
            if (issued + 5'd1 == len_q) begin
              htrans <= TRANS_IDLE;
              state  <= S_TAIL;
            end else begin
              htrans <= TRANS_SEQ;
              haddr  <= haddr + 32'd4;
            end
          end
        end

        S_TAIL: begin
          if (!resp_ok) begin
            if (hready) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_ERR;
            end
          end else if (hready && (completed + 5'd1 == len_q)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_ERR: begin
          // Second cycle of the two-cycle error response
          if (hready) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          hwrite    <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_ahb_burst_master.md
SRAM_AHB_BURST_MASTER -- requirements
Module: sram_ahb_burst_master

Interface
REQ-001 Parameter: BOUNDARY, default 1024, meaning the byte address boundary that no burst may cross.
REQ-002 hclk  in  1  single clock; all state on rising edge.
REQ-003 hreset  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept; high only in S_IDLE.
REQ-006 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  in  32  start byte address.
REQ-008 cmd_len  in  5  beat count, 1..16.
REQ-009 wd_data  in  32  write data from a show-ahead source.
REQ-010 wd_pop  out  1  one-cycle pulse: wd_data consumed.
REQ-011 rd_valid / rd_data  out  1 / 32  read beat returned.
REQ-012 done / err  out  1 / 1  command complete pulse; err is valid with done.
REQ-013 AHB master outputs: htrans[1:0], haddr[31:0], hwrite, hsize[2:0], hburst[2:0], hwdata[31:0].
REQ-014 AHB master inputs: hready, hresp[1:0], hrdata[31:0].

Function
REQ-015 FSM states: S_IDLE, S_BUS (address phases issuing), S_TAIL (final data phase, htrans IDLE), S_ERR (second ERROR cycle), S_DONE.
REQ-016 Handshake: cmd_valid && cmd_ready in cycle T latches the command.
- Aligned, legal command -> S_BUS at T+1.
- Otherwise -> S_DONE with err=1 and no bus activity.
REQ-017 A command is illegal when any of these holds:
- cmd_addr[1:0] != 0.
- cmd_len == 0 or cmd_len > 16.
- (cmd_addr mod BOUNDARY) + 4*cmd_len > BOUNDARY.
REQ-018 hburst per command: len 1 -> SINGLE 000; 4 -> INCR4 011; 8 -> INCR8 101; 16 -> INCR16 111; any other length -> INCR 001.
REQ-019 hsize is fixed at 3'b010 (word); hwrite = latched cmd_write during the burst.
REQ-020 Address phases:
- First beat: htrans=NONSEQ, haddr=cmd_addr.
- Subsequent beats: htrans=SEQ, haddr += 4.
- Each address phase advances only on a cycle with hready=1.
REQ-021 When hready=0, htrans, haddr, hwdata and hwrite are held stable.
REQ-022 After the last address phase is accepted, htrans=IDLE; state goes to S_TAIL until that data phase completes with hready=1.
REQ-023 Write data: in the cycle a write address phase is accepted (hready=1), wd_pop=1 and hwdata <= wd_data at that edge, so hwdata is valid for the whole data phase.
REQ-024 Read data: when a read data phase completes (hready=1, hresp=OKAY), rd_valid=1 and rd_data=hrdata, registered, 1 cycle later.
REQ-025 Two counters, 5 bits each:
- Issued beats; the burst ends at cmd_len.
- Completed beats; S_TAIL exits when this equals cmd_len.
REQ-026 Latency at zero wait states: accept at T, NONSEQ at T+1, last address at T+len, last data at T+len+1, done at T+len+2.
REQ-027 Error, first cycle (hresp=ERROR, hready=0):
- htrans is driven IDLE on the next cycle.
- No further beats are issued.
- State -> S_ERR.
REQ-028 Error, completion (hresp=ERROR, hready=1):
- No rd_valid for that beat.
- Next state S_DONE with err=1.
REQ-029 S_DONE lasts 1 cycle: done=1, err as determined, then -> S_IDLE; cmd_ready=0 during S_DONE.
REQ-030 htrans BUSY is never generated.
REQ-031 hresp RETRY and SPLIT are treated as ERROR.

Reset
REQ-032 Reset values while hreset=1 (asynchronous):
- htrans=IDLE, haddr=0, hwrite=0, hsize=3'b010, hburst=0, hwdata=0.
- cmd_ready=0, wd_pop=0, rd_valid=0, rd_data=0, done=0, err=0.
- FSM in S_IDLE; counters cleared.
REQ-033 First cycle after reset release: cmd_ready=1.
REQ-034 Reset asserted mid-burst drops the command silently; no done pulse is generated.

Verification
REQ-035 Write INCR4 at 0x100, hready always 1:
- Accept at T; NONSEQ 0x100 at T+1; SEQ 0x104/0x108/0x10C.
- hburst=011; 4 wd_pop pulses; done=1, err=0 at T+6.
REQ-036 Read len 3 at 0x20 with hready=0 for 2 cycles on beat 2:
- hburst=INCR; haddr/htrans held stable during the wait.
- 3 rd_valid pulses in order; done at T+7.
REQ-037 Illegal commands cmd_addr=0x3F8 len 4, and cmd_addr=0x2 len 1:
- No NONSEQ issued.
- done=1, err=1 one cycle after accept.
REQ-038 Read INCR8, slave returns ERROR on beat 3 (hready 0 then 1):
- htrans=IDLE the cycle after the first ERROR cycle.
- 2 rd_valid pulses; done=1, err=1.
REQ-039 Assert hreset during beat 2 of an INCR16 write:
- All outputs reach reset values asynchronously; no done pulse.
- After release, a new SINGLE write at 0x0 completes normally.
